serial_word_shifter: RTL

//  Parallel-to-serial stage directly upstream of the serial pattern detector.

---
 rtl/serial_word_shifter.sv | 103 ++++++++++
 1 files changed

// File: rtl/serial_word_shifter.sv
// Parallel-to-serial stage: words arrive over valid/ready and leave one bit per clock on A.
// A one-word holding register lets a following word queue up so the serial stream has no gaps.
module serial_word_shifter #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic              A,
  output logic              A_VALID,
  output logic              WORD_DONE,
  output logic              BUSY
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t            state_q;
  logic [DATA_W-1:0] sr_q;
  logic [DATA_W-1:0] hold_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              hold_full_q;

  logic [DATA_W-1:0] sr_shifted;
  logic              out_bit;
  logic              accept;
  logic              last_bit;

  // Bit order only changes which end of SR faces the serial line.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign out_bit    = sr_q[DATA_W-1];
      assign sr_shifted = {sr_q[DATA_W-2:0], 1'b0};
    end else begin : g_lsb_first
      assign out_bit    = sr_q[0];
      assign sr_shifted = {1'b0, sr_q[DATA_W-1:1]};
    end
  endgenerate

  assign IN_READY  = !RESET && !hold_full_q;
  assign accept    = IN_VALID && IN_READY;
  assign last_bit  = (cnt_q == LAST_CNT);

  assign A_VALID   = (state_q == S_SHIFT);
  assign A         = A_VALID ? out_bit : IDLE_BIT;
  assign WORD_DONE = A_VALID && last_bit;
  assign BUSY      = A_VALID || hold_full_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      sr_q        <= '0;
      hold_q      <= '0;
      cnt_q       <= '0;
      hold_full_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            sr_q    <= IN_DATA;
            cnt_q   <= '0;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (last_bit) begin
            // A queued word wins; otherwise a word offered now goes straight into SR.
            if (hold_full_q) begin
              sr_q        <= hold_q;
              hold_full_q <= 1'b0;
              cnt_q       <= '0;
            end else if (accept) begin
              sr_q  <= IN_DATA;
              cnt_q <= '0;
            end else begin
              sr_q    <= sr_shifted;
              cnt_q   <= '0;
              state_q <= S_IDLE;
            end
          end else begin
            sr_q  <= sr_shifted;
            cnt_q <= cnt_q + 1'b1;
            if (accept) begin
              hold_q      <= IN_DATA;
              hold_full_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
